multicycle_sequencer: RTL and testbench

- Control FSM that converts the single-cycle RV32I ALU datapath into a multi-cycle machine: FETCH, DECODE, EXECUTE, WRITEBACK.
- Drives the PC write enable, instruction-register load, register-file write enable, ALU op and immediate select.
- Talks to a possibly slow instruction memory through a req/ready handshake.
- Detects illegal encodings, ECALL/EBREAK halts and fetch timeouts.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/instr_decoder.sv | 47 ++++
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I control definitions: ALU op encoding, opcode constants,
// multi-cycle sequencer states and fault-cause codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_TIMEOUT = 2'b10
    } fault_cause_t;

    // Base funct3 -> ALU op mapping shared by R-type and I-type ALU instructions.
    function automatic alu_op_t funct3_to_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I ALU-subset decoder: legality, SYSTEM detection,
// ALU op and B-input select. Shared with the single-cycle control path.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal,
    output logic       is_system,
    output alu_op_t    alu_op,
    output logic       use_imm
);

    always_comb begin
        legal     = 1'b0;
        is_system = 1'b0;
        alu_op    = funct3_to_alu(funct3);
        use_imm   = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal  = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                // Only the shift immediates constrain funct7; no SRAI in this subset.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    legal = (funct7 == F7_BASE);
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                is_system = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM for the RV32I ALU datapath.
// Optional busy-cycle counter enabled by defining SEQ_CYCLE_COUNTER_EN.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop_req,
    input  logic             imem_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output alu_op_t          alu_op,
    output logic             use_imm,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles,
    output seq_state_t       seq_state
);

    localparam logic [7:0]       TIMEOUT_LIM = 8'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    seq_state_t state;
    logic [7:0] tcnt;
    logic       stop_pend;

    logic    dec_legal;
    logic    dec_system;
    alu_op_t dec_alu_op;
    logic    dec_use_imm;

    instr_decoder u_decoder (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .legal     (dec_legal),
        .is_system (dec_system),
        .alu_op    (dec_alu_op),
        .use_imm   (dec_use_imm)
    );

    assign seq_state = state;

    // Fetch handshake: imem_req is held high for every FETCH cycle; the word is
    // accepted in the first cycle imem_ready is seen high, and no request is
    // outstanding in any other state. Every output is a register (Moore).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            stop_pend   <= 1'b0;
            imem_req    <= 1'b0;
            ir_write    <= 1'b0;
            pc_write    <= 1'b0;
            reg_write   <= 1'b0;
            alu_op      <= ALU_ADD;
            use_imm     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
            retired     <= '0;
        end else begin
            imem_req  <= 1'b0;
            ir_write  <= 1'b0;
            pc_write  <= 1'b0;
            reg_write <= 1'b0;
            case (state)
                S_IDLE, S_HALT, S_FAULT: begin
                    if (start) begin
                        state       <= S_FETCH;
                        imem_req    <= 1'b1;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                        fault       <= 1'b0;
                        fault_cause <= FC_NONE;
                        tcnt        <= '0;
                        stop_pend   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (stop_req) stop_pend <= 1'b1;
                    // A ready arriving on the last permitted cycle still wins.
                    if (imem_ready) begin
                        state    <= S_DECODE;
                        ir_write <= 1'b1;
                    end else if (tcnt == TIMEOUT_LIM) begin
                        state       <= S_FAULT;
                        busy        <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                        stop_pend   <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                        tcnt     <= tcnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (stop_req) stop_pend <= 1'b1;
                    if (dec_legal) begin
                        state   <= S_EXECUTE;
                        alu_op  <= dec_alu_op;
                        use_imm <= dec_use_imm;
                    end else if (dec_system) begin
                        state     <= S_HALT;
                        busy      <= 1'b0;
                        halted    <= 1'b1;
                        stop_pend <= 1'b0;
                    end else begin
                        state       <= S_FAULT;
                        busy        <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FC_ILLEGAL;
                        stop_pend   <= 1'b0;
                    end
                end
                S_EXECUTE: begin
                    if (stop_req) stop_pend <= 1'b1;
                    state     <= S_WRITEBACK;
                    reg_write <= 1'b1;
                    pc_write  <= 1'b1;
                    retired   <= retired + CNT_ONE;
                end
                S_WRITEBACK: begin
                    if (stop_req || stop_pend) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        tcnt     <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_CYCLE_COUNTER_EN
    logic [CNT_W-1:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (busy) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
        end
    end

    assign cycles = cycle_cnt;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed instructions, event queue
// checked by an independent monitor, plus direct per-cycle strobe checks.
module tb_multicycle_sequencer;

    localparam int EV_W = 18;
    localparam logic [1:0] EV_RET = 2'd1, EV_FLT = 2'd2, EV_HLT = 2'd3;
    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_XOR = 3'd4, A_SLL = 3'd5;
`ifdef SEQ_CYCLE_COUNTER_EN
    localparam logic [31:0] EXP_CYC = 32'd4;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop_req = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        imem_req, ir_write, pc_write, reg_write, use_imm, busy, halted, fault;
    logic [2:0]  alu_op;
    logic [1:0]  fault_cause;
    logic [31:0] retired, cycles;
    logic [2:0]  seq_state;

    int n_checks = 0;
    int n_fail = 0;
    logic [EV_W-1:0] exp_q[$];
    logic [31:0] prog_q[$];
    int wait_cfg = 1;
    int req_cnt = 0;
    int fetch_cnt = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.FETCH_TIMEOUT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop_req    (stop_req),
        .imem_ready  (imem_ready),
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7      (ir[31:25]),
        .imem_req    (imem_req),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .use_imm     (use_imm),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .fault_cause (fault_cause),
        .retired     (retired),
        .cycles      (cycles),
        .seq_state   (seq_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EV_W-1:0] mk_ev(input logic [1:0] kind, input logic [2:0] alu,
                                              input logic imm, input logic rw, input logic pw,
                                              input logic [1:0] cause, input logic [7:0] ret);
        return {kind, alu, imm, rw, pw, cause, ret};
    endfunction

    // Instruction memory: ready on the wait_cfg-th request cycle (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req) begin
                req_cnt++;
                fetch_cnt++;
                imem_ready = (wait_cfg != 0) && (req_cnt >= wait_cfg);
                if (imem_ready) begin
                    req_cnt = 0;
                    if (prog_q.size() > 0) ir = prog_q.pop_front();
                end
            end else begin
                imem_ready = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Monitor: write strobes, fault entry and halt entry are the observable events.
    initial begin
        logic prev_fault, prev_halt;
        logic [1:0] kind;
        logic [EV_W-1:0] act, exp;
        prev_fault = 1'b0;
        prev_halt = 1'b0;
        forever begin
            @(negedge clk);
            kind = 2'd0;
            if (!reset_n) begin
                prev_fault = 1'b0;
                prev_halt = 1'b0;
            end else begin
                if (reg_write || pc_write) kind = EV_RET;
                else if (fault && !prev_fault) kind = EV_FLT;
                else if (halted && !prev_halt) kind = EV_HLT;
                prev_fault = fault;
                prev_halt = halted;
            end
            if (kind != 2'd0) begin
                if (kind == EV_RET)
                    act = mk_ev(kind, alu_op, use_imm, reg_write, pc_write, fault_cause, retired[7:0]);
                else
                    act = mk_ev(kind, 3'd0, 1'b0, reg_write, pc_write, fault_cause, retired[7:0]);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 64'(act), 64'(0));
                end else begin
                    exp = exp_q.pop_front();
                    chk("event", 64'(act), 64'(exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(busy), 64'(0));
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset_strobes", 64'({busy, imem_req, ir_write, reg_write, pc_write, use_imm,
                                  halted, fault, fault_cause, alu_op}), 64'(0));
        chk("reset_retired", 64'(retired), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));

        // addi x1,x0,10 with stop in FETCH: strobe order and single retirement
        prog_q.push_back(32'h00A00093);
        exp_q.push_back(mk_ev(EV_RET, A_ADD, 1'b1, 1'b1, 1'b1, 2'b00, 8'd1));
        kick();
        stop_req = 1'b1;
        chk("c1_fetch", 64'({imem_req, ir_write, reg_write, pc_write, busy}), 64'(5'b10001));
        @(negedge clk);
        stop_req = 1'b0;
        chk("c2_decode", 64'({imem_req, ir_write, reg_write, pc_write}), 64'(4'b0100));
        @(negedge clk);
        chk("c3_execute", 64'({imem_req, ir_write, reg_write, pc_write}), 64'(4'b0000));
        chk("c3_alu", 64'({alu_op, use_imm}), 64'({A_ADD, 1'b1}));
        @(negedge clk);
        chk("c4_writeback", 64'({imem_req, ir_write, reg_write, pc_write}), 64'(4'b0011));
        chk("c4_retired", 64'(retired), 64'(1));
        @(negedge clk);
        chk("stop_idle", 64'({busy, imem_req}), 64'(0));
        chk("cycles", 64'(cycles), 64'(EXP_CYC));

        // sub then xor back to back, stop during second FETCH
        prog_q.push_back(32'h40208033);
        prog_q.push_back(32'h0020C033);
        exp_q.push_back(mk_ev(EV_RET, A_SUB, 1'b0, 1'b1, 1'b1, 2'b00, 8'd2));
        exp_q.push_back(mk_ev(EV_RET, A_XOR, 1'b0, 1'b1, 1'b1, 2'b00, 8'd3));
        kick();
        repeat (4) @(negedge clk);
        chk("second_fetch", 64'(imem_req), 64'(1));
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("c8_retired", 64'({reg_write, retired}), 64'({1'b1, 32'd3}));
        @(negedge clk);
        chk("pair_idle", 64'(busy), 64'(0));

        // Illegal R-type funct7 and illegal SRAI-style shift
        prog_q.push_back(32'h02208033);
        exp_q.push_back(mk_ev(EV_FLT, 3'd0, 1'b0, 1'b0, 1'b0, 2'b01, 8'd3));
        kick();
        wait_idle("illegal_r_idle", 20);
        chk("illegal_r_fault", 64'({fault, fault_cause}), 64'({1'b1, 2'b01}));
        prog_q.push_back(32'h40305093);
        exp_q.push_back(mk_ev(EV_FLT, 3'd0, 1'b0, 1'b0, 1'b0, 2'b01, 8'd3));
        kick();
        chk("fault_clears", 64'({fault, fault_cause, imem_req}), 64'({1'b0, 2'b00, 1'b1}));
        wait_idle("illegal_i_idle", 20);
        chk("illegal_i_fault", 64'({fault, fault_cause}), 64'({1'b1, 2'b01}));

        // Recovery with andi
        prog_q.push_back(32'h0FF0F093);
        exp_q.push_back(mk_ev(EV_RET, A_AND, 1'b1, 1'b1, 1'b1, 2'b00, 8'd4));
        kick();
        stop_req = 1'b1;
        chk("resume_fetch", 64'({fault, fault_cause, imem_req}), 64'({1'b0, 2'b00, 1'b1}));
        @(negedge clk);
        stop_req = 1'b0;
        wait_idle("andi_idle", 20);

        // Fetch timeout: no ready for 16 cycles
        wait_cfg = 0;
        fetch_cnt = 0;
        exp_q.push_back(mk_ev(EV_FLT, 3'd0, 1'b0, 1'b0, 1'b0, 2'b10, 8'd4));
        kick();
        wait_idle("timeout_idle", 40);
        chk("timeout_fetch_cycles", 64'(fetch_cnt), 64'(16));
        chk("timeout_cause", 64'({fault, fault_cause}), 64'({1'b1, 2'b10}));

        // Ready exactly on the 16th FETCH cycle wins
        wait_cfg = 16;
        fetch_cnt = 0;
        prog_q.push_back(32'h00309093);
        exp_q.push_back(mk_ev(EV_RET, A_SLL, 1'b1, 1'b1, 1'b1, 2'b00, 8'd5));
        kick();
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        wait_idle("late_ready_idle", 40);
        chk("late_ready_fetch_cycles", 64'(fetch_cnt), 64'(16));
        chk("late_ready_no_fault", 64'({fault, fault_cause}), 64'(0));

        // ecall halts without retiring
        wait_cfg = 1;
        prog_q.push_back(32'h00000073);
        exp_q.push_back(mk_ev(EV_HLT, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd5));
        kick();
        wait_idle("ecall_idle", 20);
        chk("ecall_halted", 64'({halted, fault, retired}), 64'({1'b1, 1'b0, 32'd5}));

        // Asynchronous reset during EXECUTE
        prog_q.push_back(32'h00A00093);
        kick();
        chk("restart_clears_halt", 64'(halted), 64'(0));
        @(negedge clk);
        @(negedge clk);
        chk("exec_alu", 64'({alu_op, use_imm}), 64'({A_ADD, 1'b1}));
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_strobes", 64'({busy, imem_req, ir_write, reg_write, pc_write, use_imm,
                                        halted, fault, fault_cause, alu_op}), 64'(0));
        chk("async_reset_counters", 64'({retired, cycles}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle", 64'({busy, reg_write, retired}), 64'(0));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
